// File: rtl/pe_inject_ctrl.sv
// pe_inject_ctrl: injection-side controller between a processing element and
// the PE injection port of a dimension-ordered mesh router.
// - Buffers PE packets in a DEPTH-entry FIFO and presents the head as
//   (i_x, i_y, i_d, i_v).
// - Pops the head on i_ack.
// - Flags starvation when the head is refused STARVE_LIM cycles in a row.
// Optional macro PE_INJ_STATS_EN adds inj_cnt / stall_cnt statistics outputs.
module pe_inject_ctrl #(
   parameter int X_W        = 2,
   parameter int Y_W        = 2,
   parameter int D_W        = 32,
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [X_W-1:0]           pe_x,
   input  logic [Y_W-1:0]           pe_y,
   input  logic [D_W-1:0]           pe_d,
   input  logic                     pe_v,
   output logic                     pe_rdy,
   output logic [X_W-1:0]           i_x,
   output logic [Y_W-1:0]           i_y,
   output logic [D_W-1:0]           i_d,
   output logic                     i_v,
   input  logic                     i_ack,
   output logic                     starve,
   output logic [$clog2(DEPTH):0]   count
`ifdef PE_INJ_STATS_EN
   ,
   output logic [31:0]              inj_cnt,
   output logic [31:0]              stall_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = X_W + Y_W + D_W;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [7:0]    LIM  = 8'(STARVE_LIM);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      STARVED = 2'd2
   } state_t;

   // Packet storage: data only, never reset (occupancy lives in count_q)
   logic [PW-1:0]  mem_q [DEPTH];

   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q,  count_d;
   state_t         state_q,  state_d;
   logic [7:0]     wcnt_q,   wcnt_d;
   logic           starve_q, starve_d;
   logic           push, pop;
   logic [PW-1:0]  pkt_in;
   logic [PW-1:0]  head;

`ifdef PE_INJ_STATS_EN
   logic [31:0]    inj_cnt_q,   inj_cnt_d;
   logic [31:0]    stall_cnt_q, stall_cnt_d;
`endif

   // pe_rdy looks only at registered occupancy, so a same-cycle pop does not
   // open a slot for the PE; there is no bypass from PE to router either.
   assign pe_rdy = (count_q != FULL);
   assign i_v    = (count_q != '0);
   assign push   = pe_v && pe_rdy;
   assign pop    = i_v && i_ack;
   assign pkt_in = {pe_x, pe_y, pe_d};
   assign head   = mem_q[rd_ptr_q];
   assign i_x    = head[PW-1 -: X_W];
   assign i_y    = head[D_W+Y_W-1 -: Y_W];
   assign i_d    = head[D_W-1:0];
   assign count  = count_q;
   assign starve = starve_q;

`ifdef PE_INJ_STATS_EN
   assign inj_cnt   = inj_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

   // Next-state: FIFO pointers/occupancy and the starvation FSM with its wait counter
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            wcnt_d = 8'd0;
            if (count_d != '0) state_d = PEND;
         end
         PEND: begin
            if (pop) begin
               wcnt_d  = 8'd0;
               state_d = (count_d == '0) ? IDLE : PEND;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
               if (wcnt_q + 8'd1 == LIM) state_d = STARVED;
            end
         end
         STARVED: begin
            // wcnt saturates here until the head is finally accepted
            if (pop) begin
               wcnt_d  = 8'd0;
               state_d = (count_d == '0) ? IDLE : PEND;
            end
         end
         default: begin
            wcnt_d  = 8'd0;
            state_d = IDLE;
         end
      endcase
      starve_d = (state_d == STARVED);

`ifdef PE_INJ_STATS_EN
      inj_cnt_d   = inj_cnt_q + 32'(pop);
      stall_cnt_d = stall_cnt_q + 32'(i_v && !i_ack);
`endif
   end

   // Control state with synchronous reset; reset discards every queued entry
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         wcnt_q      <= 8'd0;
         starve_q    <= 1'b0;
`ifdef PE_INJ_STATS_EN
         inj_cnt_q   <= 32'd0;
         stall_cnt_q <= 32'd0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         starve_q    <= starve_d;
`ifdef PE_INJ_STATS_EN
         inj_cnt_q   <= inj_cnt_d;
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

   // Packet write port: payload storage carries no reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= pkt_in;
   end

endmodule

// File: tb/tb_pe_inject_ctrl.sv
// tb_pe_inject_ctrl: directed scoreboard bench for pe_inject_ctrl.
// Expected packets are queued when the stimulus issues an accepted push; a
// monitor pops and compares whenever the router side accepts a head.
// Build with +define+PE_INJ_STATS_EN to also cover the statistics counters.
module tb_pe_inject_ctrl;

   typedef struct packed {
      logic [1:0]  x;
      logic [1:0]  y;
      logic [31:0] d;
   } pkt_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pe_x, pe_y;
   logic [31:0] pe_d;
   logic        pe_v;
   logic        pe_rdy;
   logic [1:0]  i_x, i_y;
   logic [31:0] i_d;
   logic        i_v;
   logic        i_ack;
   logic        starve;
   logic [2:0]  count;
`ifdef PE_INJ_STATS_EN
   logic [31:0] inj_cnt, stall_cnt;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   pkt_t exp_q[$];

   pe_inject_ctrl #(
      .X_W(2), .Y_W(2), .D_W(32), .DEPTH(4), .STARVE_LIM(8)
   ) dut (
      .clk(clk), .rst(rst),
      .pe_x(pe_x), .pe_y(pe_y), .pe_d(pe_d), .pe_v(pe_v), .pe_rdy(pe_rdy),
      .i_x(i_x), .i_y(i_y), .i_d(i_d), .i_v(i_v), .i_ack(i_ack),
      .starve(starve), .count(count)
`ifdef PE_INJ_STATS_EN
      , .inj_cnt(inj_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // advance one cycle; inputs change and checks happen 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] x, input logic [1:0] y,
                        input logic [31:0] d, input bit accepted);
      pe_v = v; pe_x = x; pe_y = y; pe_d = d;
      if (v && accepted) exp_q.push_back('{x: x, y: y, d: d});
   endtask

   // scoreboard monitor: compares every head the router accepts
   always @(negedge clk) begin
      if (!rst && i_v === 1'b1 && i_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", {30'd0, i_x}, 32'hDEAD);
         end else begin
            pkt_t e;
            e = exp_q.pop_front();
            chk("head_x", {30'd0, i_x}, {30'd0, e.x});
            chk("head_y", {30'd0, i_y}, {30'd0, e.y});
            chk("head_d", i_d, e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_ack = 1'b0;
      drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      step(); step();
      rst = 1'b0;
      // reset state
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_iv", 32'(i_v), 32'd0);
      chk("rst_rdy", 32'(pe_rdy), 32'd1);
      chk("rst_starve", 32'(starve), 32'd0);

      // single packet, immediate accept
      i_ack = 1'b1;
      drive(1'b1, 2'd1, 2'd2, 32'hA5, 1'b1);
      step();
      drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      chk("t1_iv_c1", 32'(i_v), 32'd1);
      chk("t1_count_c1", 32'(count), 32'd1);
      step();
      chk("t1_iv_c2", 32'(i_v), 32'd0);
      chk("t1_count_c2", 32'(count), 32'd0);

      // fill with i_ack low
      i_ack = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 2'(k), 2'(k + 1), 32'(k), 1'b1);
         step();
      end
      chk("t2_count_full", 32'(count), 32'd4);
      chk("t2_rdy_full", 32'(pe_rdy), 32'd0);
      drive(1'b1, 2'd3, 2'd3, 32'd5, 1'b0);
      step();
      chk("t2_count_refuse", 32'(count), 32'd4);
      chk("t2_head_d", i_d, 32'd1);

      // full plus simultaneous push/pop: pop happens, push refused
      i_ack = 1'b1;
      drive(1'b1, 2'd0, 2'd1, 32'h99, 1'b0);
      step();
      drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      chk("t3_count", 32'(count), 32'd3);
      step(); step(); step();
      i_ack = 1'b0;
      chk("t3_drained", 32'(count), 32'd0);
      chk("t3_rdy", 32'(pe_rdy), 32'd1);

      // starvation with two packets queued
      drive(1'b1, 2'd2, 2'd1, 32'h5A, 1'b1);
      step();
      drive(1'b1, 2'd1, 2'd3, 32'h6B, 1'b1);
      chk("t4_starve_r1", 32'(starve), 32'd0);
      step();
      drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      for (int r = 2; r <= 8; r++) begin
         chk("t4_starve_low", 32'(starve), 32'd0);
         chk("t4_hold_d", i_d, 32'h5A);
         step();
      end
      chk("t4_starve_rise", 32'(starve), 32'd1);
      step(); step();
      chk("t4_starve_held", 32'(starve), 32'd1);
      chk("t4_hold_d_late", i_d, 32'h5A);
      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      chk("t4_starve_fall", 32'(starve), 32'd0);
      chk("t4_next_head", i_d, 32'h6B);
      // wait counter restarted: 8 fresh refusals needed again
      for (int r = 1; r <= 8; r++) begin
         chk("t4_restart_low", 32'(starve), 32'd0);
         step();
      end
      chk("t4_restart_rise", 32'(starve), 32'd1);
      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      chk("t4_end_starve", 32'(starve), 32'd0);
      chk("t4_end_count", 32'(count), 32'd0);

      // reset mid-operation
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'(k), 2'(k), 32'h31 + 32'(k), 1'b1);
         step();
      end
      drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      for (int r = 0; r < 8; r++) step();
      chk("t5_pre_starve", 32'(starve), 32'd1);
      chk("t5_pre_count", 32'(count), 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_iv", 32'(i_v), 32'd0);
      chk("t5_starve", 32'(starve), 32'd0);
      chk("t5_rdy", 32'(pe_rdy), 32'd1);
      i_ack = 1'b1;
      drive(1'b1, 2'd3, 2'd3, 32'h77, 1'b1);
      step();
      drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      chk("t5_fresh_iv", 32'(i_v), 32'd1);
      step();
      chk("t5_fresh_gone", 32'(i_v), 32'd0);
      i_ack = 1'b0;

`ifdef PE_INJ_STATS_EN
      // statistics: 5 packets, each refused twice then accepted
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_rst_inj", inj_cnt, 32'd0);
      chk("t6_rst_stall", stall_cnt, 32'd0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 2'(k), 2'(k + 2), 32'h100 + 32'(k), 1'b1);
         step();
         drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
         step(); step();
         i_ack = 1'b1;
         step();
         i_ack = 1'b0;
      end
      chk("t6_inj_cnt", inj_cnt, 32'd5);
      chk("t6_stall_cnt", stall_cnt, 32'd10);
`endif

      step();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_inject_ctrl.md
Name: pe_inject_ctrl

Overview:
- Injection-side controller between a processing element (PE) and the PE injection port of a mesh router that uses the dimension-ordered routing function.
- Buffers outgoing PE packets in a small FIFO and presents the head packet to the router as (i_x, i_y, i_d, i_v).
- Pops the head on the router's i_ack.
- Tracks how long the head has been refused and raises a starvation flag so upper layers can throttle the PE or raise the injection priority.

Parameters:
- X_W, 2, X address width
- Y_W, 2, Y address width
- D_W, 32, payload width
- DEPTH, 4, FIFO entries; power of 2, >= 2
- STARVE_LIM, 8, consecutive refused cycles before starve asserts; 1..255

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pe_x  input  X_W  destination X of the PE packet
- pe_y  input  Y_W  destination Y of the PE packet
- pe_d  input  D_W  PE payload
- pe_v  input  1  PE packet valid
- pe_rdy  output  1  FIFO can accept; equals not-full
- i_x  output  X_W  head destination X to router
- i_y  output  Y_W  head destination Y to router
- i_d  output  D_W  head payload to router
- i_v  output  1  head valid to router
- i_ack  input  1  router accepted the head this cycle
- starve  output  1  head refused for STARVE_LIM consecutive cycles
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: count=0, i_v=0, pe_rdy=1, starve=0, FSM=IDLE. i_x, i_y and i_d are don't-care while i_v=0; the bench must not check them.
- Push:
  - Push happens when pe_v && pe_rdy.
  - pe_rdy is derived from registered count only (count != DEPTH). A pop in the same cycle does not raise pe_rdy.
- Pop: happens when i_v && i_ack. i_ack while i_v=0 is ignored.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- No bypass: a packet pushed into an empty FIFO appears on i_v exactly 1 cycle later. Minimum PE-to-router latency is 1 cycle.
- Head presentation:
  - i_v = (count != 0).
  - i_x, i_y, i_d come from the head entry and stay stable while i_v && !i_ack.
- Pointers: rd_ptr and wr_ptr wrap modulo DEPTH. Occupancy is tracked by a separate count register (DEPTH+1 states).
- Starvation FSM, with an 8-bit wait counter wcnt:
  - IDLE: count==0; wcnt=0.
    - Goes to PEND when count becomes nonzero.
  - PEND: i_v=1, wcnt < STARVE_LIM.
    - Each cycle with !i_ack: wcnt++.
    - On i_ack: wcnt=0; go to IDLE if the FIFO becomes empty, else stay in PEND.
    - Go to STARVED when the increment makes wcnt == STARVE_LIM.
  - STARVED: starve=1; wcnt holds (saturates).
    - On i_ack: wcnt=0; go to PEND, or to IDLE if the FIFO becomes empty.
- starve is a registered output: it rises the cycle after the STARVE_LIM-th refused cycle and falls the cycle after the accepting i_ack.
- Reset mid-operation: all entries are discarded and the FSM goes to IDLE. The next cycle shows i_v=0, starve=0, pe_rdy=1.

Optional Feature:
- Macro: PE_INJ_STATS_EN.
- When defined, two extra outputs exist:
  - inj_cnt [31:0]: increments on every pop.
  - stall_cnt [31:0]: increments on every cycle with i_v && !i_ack.
- Both counters wrap at 2^32 and reset to 0 on rst.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single packet, immediate accept: push (x=1, y=2, d=0xA5) at cycle 0 with i_ack tied 1 → i_v=1 at cycle 1 showing x=1, y=2, d=0xA5; i_v=0 at cycle 2; count returns 0.
- Fill with i_ack=0: 4 back-to-back pushes (d=1..4), DEPTH=4 → count=4, pe_rdy=0 after the 4th push; a 5th pe_v is not accepted; heads pop in order 1,2,3,4 once i_ack=1.
- Full plus simultaneous push/pop: FIFO full, i_ack=1 and pe_v=1 in the same cycle → pop occurs, push is refused (pe_rdy was 0), count=3.
- Starvation: 1 packet, i_ack=0 for 8 cycles, STARVE_LIM=8 → starve=1 in the following cycle and held; i_ack=1 → starve=0 the next cycle; wcnt resets; i_d unchanged throughout the stall.
- Reset mid-operation: 3 entries queued, starve=1, rst pulsed 1 cycle → next cycle count=0, i_v=0, starve=0, pe_rdy=1; a fresh push is presented 1 cycle later.
- PE_INJ_STATS_EN: 5 packets, each refused 2 cycles then accepted → inj_cnt=5, stall_cnt=10.
